// File: rtl/flag_pkg.sv
// Shared types and helpers for the per-cell flag bank of the minesweeper board.
package flag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TOGGLE = 2'd1,
        ST_CLEAR  = 2'd2
    } flag_state_e;

    localparam logic [9:0] DEFAULT_FLAG_PATTERN = 10'b1111111011;

    // Linear cell index, row-major: y*cols + x.
    function automatic logic [7:0] idx(input logic [3:0] x, input logic [3:0] y, input int cols);
        return 8'(int'(y) * cols + int'(x));
    endfunction

endpackage

// File: rtl/sw_sync_edge.sv
// Synchronises an asynchronous switch bus, matches it against a fixed pattern
// and emits a single-cycle pulse each time the pattern is newly entered.
module sw_sync_edge #(
    parameter int           W       = 10,
    parameter logic [W-1:0] PATTERN = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_i,
    output logic         trig_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic         match;
    logic         match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            match_q <= 1'b0;
        end else begin
            s1_q    <= sw_i;
            s2_q    <= s1_q;
            match_q <= match;
        end
    end

    assign match  = (s2_q == PATTERN);
    assign trig_o = match & ~match_q;

endmodule

// File: rtl/flag_bank.sv
// One flag bit per board cell: switch-triggered toggle with mine-budget and
// revealed-cell refusal, a one-cell-per-cycle clear sweep, and a read port.
module flag_bank
    import flag_pkg::*;
#(
    parameter int                 COLS         = 8,
    parameter int                 ROWS         = 8,
    parameter int                 MAX_FLAGS    = 10,
    parameter int                 CMD_W        = 10,
    parameter logic [CMD_W-1:0]   FLAG_PATTERN = CMD_W'(DEFAULT_FLAG_PATTERN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            cursor_x,
    input  logic [3:0]            cursor_y,
    input  logic [CMD_W-1:0]      cmd_sw,
    input  logic                  clear_all,
    input  logic [COLS*ROWS-1:0]  reveal_mask,
    input  logic [3:0]            rd_x,
    input  logic [3:0]            rd_y,
    output logic                  rd_flag,
    output logic [COLS*ROWS-1:0]  flag_mask,
    output logic [4:0]            flag_count,
    output logic [3:0]            last_x,
    output logic [3:0]            last_y,
    output logic                  busy,
    output logic                  err_full,
    output logic                  err_revealed,
    output logic                  err_range
);

    localparam int                N        = COLS * ROWS;
    localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]      ONE      = N'(1);
    localparam logic [4:0]        MAX_CNT  = 5'(MAX_FLAGS);
    localparam logic [4:0]        COLS_L   = 5'(COLS);
    localparam logic [4:0]        ROWS_L   = 5'(ROWS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    flag_state_e      state_q, state_d;
    logic [N-1:0]     flag_q, flag_d;
    logic [4:0]       count_q, count_d;
    logic [3:0]       last_x_q, last_x_d;
    logic [3:0]       last_y_q, last_y_d;
    logic [3:0]       cx_q, cx_d;
    logic [3:0]       cy_q, cy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_full_q, err_full_d;
    logic             err_rev_q, err_rev_d;
    logic             err_range_q, err_range_d;

    logic             trig;
    logic [N-1:0]     cur_bit;
    logic [N-1:0]     clr_bit;
    logic [N-1:0]     rd_bit;
    logic             cur_flag;
    logic             cur_rev;
    logic             clr_flag;
    logic             rd_in_range;

    // A trigger is a one-cycle pulse; it is acted on only in IDLE, so any
    // trigger that arrives while busy is high is simply lost.
    sw_sync_edge #(
        .W       (CMD_W),
        .PATTERN (FLAG_PATTERN)
    ) u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .sw_i   (cmd_sw),
        .trig_o (trig)
    );

    // Shift-based bit selection: an index past the board yields an all-zero mask.
    assign cur_bit  = ONE << idx(cx_q, cy_q, COLS);
    assign clr_bit  = ONE << idx_q;
    assign rd_bit   = ONE << idx(rd_x, rd_y, COLS);
    assign cur_flag = |(flag_q & cur_bit);
    assign cur_rev  = |(reveal_mask & cur_bit);
    assign clr_flag = |(flag_q & clr_bit);

    assign rd_in_range = ({1'b0, rd_x} < COLS_L) && ({1'b0, rd_y} < ROWS_L);
    assign rd_flag     = rd_in_range & |(flag_q & rd_bit);

    always_comb begin
        state_d     = state_q;
        flag_d      = flag_q;
        count_d     = count_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        idx_d       = idx_q;
        err_full_d  = 1'b0;
        err_rev_d   = 1'b0;
        err_range_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_all) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else if (trig) begin
                    cx_d = cursor_x;
                    cy_d = cursor_y;
                    if (({1'b0, cursor_x} >= COLS_L) || ({1'b0, cursor_y} >= ROWS_L)) begin
                        err_range_d = 1'b1;
                    end else begin
                        state_d = ST_TOGGLE;
                    end
                end
            end
            ST_TOGGLE: begin
                state_d = ST_IDLE;
                if (cur_flag) begin
                    flag_d   = flag_q & ~cur_bit;
                    count_d  = (count_q != 5'd0) ? count_q - 5'd1 : count_q;
                    last_x_d = cx_q;
                    last_y_d = cy_q;
                end else if (cur_rev) begin
                    err_rev_d = 1'b1;
                end else if (count_q >= MAX_CNT) begin
                    err_full_d = 1'b1;
                end else begin
                    flag_d   = flag_q | cur_bit;
                    count_d  = count_q + 5'd1;
                    last_x_d = cx_q;
                    last_y_d = cy_q;
                end
            end
            ST_CLEAR: begin
                if (clr_flag) begin
                    flag_d  = flag_q & ~clr_bit;
                    count_d = (count_q != 5'd0) ? count_q - 5'd1 : count_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            flag_q      <= '0;
            count_q     <= '0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            idx_q       <= '0;
            err_full_q  <= 1'b0;
            err_rev_q   <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            count_q     <= count_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            idx_q       <= idx_d;
            err_full_q  <= err_full_d;
            err_rev_q   <= err_rev_d;
            err_range_q <= err_range_d;
        end
    end

    assign flag_mask    = flag_q;
    assign flag_count   = count_q;
    assign last_x       = last_x_q;
    assign last_y       = last_y_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_full     = err_full_q;
    assign err_revealed = err_rev_q;
    assign err_range    = err_range_q;

endmodule

// File: tb/tb_flag_bank.sv
// Directed bench for flag_bank (8x8 board, budget 10): one expected record per
// operation is queued by the stimulus and popped by a monitor on each DUT event.
module tb_flag_bank;

    localparam logic [9:0] PAT = 10'b1111111011;
    localparam int RW = 89;

    logic        clk;
    logic        reset;
    logic [3:0]  cursor_x, cursor_y;
    logic [9:0]  cmd_sw;
    logic        clear_all;
    logic [63:0] reveal_mask;
    logic [3:0]  rd_x, rd_y;
    logic        rd_flag;
    logic [63:0] flag_mask;
    logic [4:0]  flag_count;
    logic [3:0]  last_x, last_y;
    logic        busy, err_full, err_revealed, err_range;

    logic [RW-1:0] exp_q[$];
    int checks;
    int failures;

    logic [63:0] m_mask;
    int          m_count;
    logic [3:0]  m_lx, m_ly;

    flag_bank dut (
        .clk          (clk),
        .reset        (reset),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .cmd_sw       (cmd_sw),
        .clear_all    (clear_all),
        .reveal_mask  (reveal_mask),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_flag      (rd_flag),
        .flag_mask    (flag_mask),
        .flag_count   (flag_count),
        .last_x       (last_x),
        .last_y       (last_y),
        .busy         (busy),
        .err_full     (err_full),
        .err_revealed (err_revealed),
        .err_range    (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record: {busy_len, err_full, err_revealed, err_range, count, last_x, last_y, mask}
    function automatic logic [RW-1:0] mk_rec(input logic [8:0] len, input logic ef, input logic er,
                                             input logic eg, input logic [4:0] cnt, input logic [3:0] lx,
                                             input logic [3:0] ly, input logic [63:0] mask);
        return {len, ef, er, eg, cnt, lx, ly, mask};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic toggle_cell(input int x, input int y, input int hold);
        logic [8:0] len;
        logic ef, er, eg;
        int c;
        ef = 1'b0; er = 1'b0; eg = 1'b0; len = 9'd0;
        if (x >= 8 || y >= 8) begin
            eg = 1'b1;
        end else begin
            c   = y * 8 + x;
            len = 9'd1;
            if (m_mask[c]) begin
                m_mask[c] = 1'b0; m_count--; m_lx = 4'(x); m_ly = 4'(y);
            end else if (reveal_mask[c]) begin
                er = 1'b1;
            end else if (m_count == 10) begin
                ef = 1'b1;
            end else begin
                m_mask[c] = 1'b1; m_count++; m_lx = 4'(x); m_ly = 4'(y);
            end
        end
        exp_q.push_back(mk_rec(len, ef, er, eg, 5'(m_count), m_lx, m_ly, m_mask));
        @(negedge clk);
        cursor_x = 4'(x);
        cursor_y = 4'(y);
        cmd_sw   = PAT;
        repeat (hold) @(negedge clk);
        cmd_sw = '0;
        repeat (4) @(negedge clk);
        drain(20);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mask"}, flag_mask, 64'd0);
        chk({tag, "_count"}, 64'(flag_count), 64'd0);
        chk({tag, "_last"}, 64'({last_x, last_y}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_errs"}, 64'({err_full, err_revealed, err_range}), 64'd0);
        chk({tag, "_rd"}, 64'(rd_flag), 64'd0);
    endtask

    initial begin : monitor
        logic busy_prev;
        int len;
        logic [RW-1:0] act, exp;
        busy_prev = 1'b0;
        len = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_prev = 1'b0;
                len = 0;
            end else begin
                if (busy) len++;
                if ((busy_prev && !busy) || err_full || err_revealed || err_range) begin
                    act = mk_rec(9'(len), err_full, err_revealed, err_range, flag_count,
                                 last_x, last_y, flag_mask);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event actual=%h required=none", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            failures++;
                            $display("FAIL event len=%0d/%0d errs=%b/%b count=%0d/%0d last=%h/%h mask=%h/%h",
                                     act[88:80], exp[88:80], act[79:77], exp[79:77], act[76:72], exp[76:72],
                                     act[71:64], exp[71:64], act[63:0], exp[63:0]);
                        end
                    end
                    len = 0;
                end
                busy_prev = busy;
            end
        end
    end

    initial begin : stimulus
        checks = 0; failures = 0;
        m_mask = '0; m_count = 0; m_lx = '0; m_ly = '0;
        reset = 1'b0; cursor_x = '0; cursor_y = '0; cmd_sw = '0; clear_all = 1'b0;
        reveal_mask = '0; rd_x = 4'd2; rd_y = 4'd3;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        // First flag at (2,3) -> cell 26.
        toggle_cell(2, 3, 6);
        chk("t1_bit26", 64'(flag_mask[26]), 64'd1);
        chk("t1_count", 64'(flag_count), 64'd1);
        chk("t1_last", 64'({last_x, last_y}), 64'h23);
        rd_x = 4'd2; rd_y = 4'd3; #1;
        chk("rd_2_3", 64'(rd_flag), 64'd1);
        rd_x = 4'd3; rd_y = 4'd2; #1;
        chk("rd_3_2", 64'(rd_flag), 64'd0);
        rd_x = 4'd10; rd_y = 4'd2; #1;
        chk("rd_out_of_range", 64'(rd_flag), 64'd0);

        // Re-entry held for 20 cycles clears it exactly once.
        toggle_cell(2, 3, 20);
        chk("t2_bit26", 64'(flag_mask[26]), 64'd0);
        chk("t2_count", 64'(flag_count), 64'd0);

        reveal_mask[26] = 1'b1;
        toggle_cell(2, 3, 6);
        chk("t3_count", 64'(flag_count), 64'd0);

        for (int i = 0; i < 10; i++) toggle_cell(i % 8, i / 8, 6);
        chk("t4_count10", 64'(flag_count), 64'd10);
        toggle_cell(5, 5, 6);
        chk("t4_full_count", 64'(flag_count), 64'd10);
        toggle_cell(3, 0, 6);
        chk("t4_count9", 64'(flag_count), 64'd9);
        toggle_cell(3, 0, 6);

        toggle_cell(9, 0, 6);
        toggle_cell(0, 8, 6);
        chk("t5_count", 64'(flag_count), 64'd10);
        chk("t5_last", 64'({last_x, last_y}), 64'h30);

        // Clear-all coinciding with a trigger, plus a re-entry during the sweep.
        exp_q.push_back(mk_rec(9'd64, 1'b0, 1'b0, 1'b0, 5'd0, m_lx, m_ly, 64'd0));
        m_mask = '0; m_count = 0;
        @(negedge clk);
        cursor_x = 4'd4; cursor_y = 4'd4; cmd_sw = PAT;
        repeat (2) @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        chk("clr_busy", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        cmd_sw = '0;
        repeat (10) @(negedge clk);
        cmd_sw = PAT;
        drain(80);
        repeat (4) @(negedge clk);
        cmd_sw = '0;
        repeat (4) @(negedge clk);
        chk("clr_count", 64'(flag_count), 64'd0);
        chk("clr_mask", flag_mask, 64'd0);
        chk("clr_last", 64'({last_x, last_y}), 64'h30);

        // Sweep aborted by reset at cycle 30.
        toggle_cell(7, 7, 6);
        toggle_cell(6, 7, 6);
        toggle_cell(0, 5, 6);
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        repeat (29) @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_count_pre", 64'(flag_count), 64'd3);
        #2 reset = 1'b0;
        #1;
        rd_x = 4'd7; rd_y = 4'd7; #1;
        check_reset_state("abort");
        m_mask = '0; m_count = 0; m_lx = '0; m_ly = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        toggle_cell(1, 1, 6);
        chk("post_count", 64'(flag_count), 64'd1);
        chk("post_last", 64'({last_x, last_y}), 64'h11);

        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
